// File: rtl/sched_pkg.sv
// sched_pkg: shared types and constants for the channel readout scheduler.
// Contents: scheduler state encoding, record-header field positions,
// record/hold lengths and a header-byte builder.
package sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_SEND,
        ST_UNLOAD,
        ST_HOLD
    } state_t;

    localparam int HDR_OVR_BIT  = 7;
    localparam int HDR_CHAN_MSB = 3;

    localparam int RECORD_BYTES = 8;
    localparam int HOLD_CYCLES  = 2;
    localparam int HOLD_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    // Header: overrun flag in the top bit, channel index in the low nibble,
    // everything in between reads as zero.
    function automatic logic [7:0] make_header(input logic ovr,
                                               input logic [HDR_CHAN_MSB:0] idx);
        logic [7:0] h;
        h = '0;
        h[HDR_OVR_BIT]      = ovr;
        h[HDR_CHAN_MSB:0]   = idx;
        return h;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Returns the first set bit of req at or after ptr, wrapping modulo NCHAN.
// Ports:
//   req       in  NCHAN  request vector
//   ptr       in  IDXW   search start index (always < NCHAN)
//   grant_idx out IDXW   index of the chosen request (0 when none)
//   any       out 1      at least one request is set
module rr_arbiter #(
    parameter int NCHAN = 4,
    parameter int IDXW  = 2
) (
    input  logic [NCHAN-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic [IDXW-1:0]  grant_idx,
    output logic             any
);

    function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] p, input int k);
        int j;
        j = int'(p) + k;
        if (j >= NCHAN) j = j - NCHAN;
        return IDXW'(j);
    endfunction

    // Scan offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        for (int k = NCHAN - 1; k >= 0; k--) begin
            if (req[wrap_idx(ptr, k)]) begin
                grant_idx = wrap_idx(ptr, k);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_scheduler.sv
// channel_scheduler: shares one host byte stream among NCHAN event-logger
// channels. Each granted channel produces either a 9-byte data record
// (header + 8 timestamp bytes, LSB first, followed by an unload pulse) or a
// header-only overrun record (followed by a clearoverrun pulse).
//
// Ports:
//   clk           in   1        clock shared with the channels
//   rst           in   1        synchronous active-high reset
//   attention     in   NCHAN    channel has data or a latched overrun (1-clk lag)
//   overrun       in   NCHAN    latched overrun flags
//   chandata      in   8*NCHAN  per-channel byte selected by byteaddr
//   byteaddr      out  3        byte select broadcast to all channels
//   unload        out  NCHAN    one-cycle one-hot FIFO pop
//   clearoverrun  out  NCHAN    one-cycle one-hot overrun clear
//   txdata        out  8        registered output byte
//   txvalid       out  1        txdata valid
//   txready       in   1        host accepts the byte
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | wait for attention; pick channel, load header
// HDR     | header offered to host
// FETCH   | capture channel byte at byteaddr into txdata
// SEND    | payload byte offered to host
// UNLOAD  | unload pulse to the granted channel
// HOLD    | let FIFO flags and the lagging attention settle before regrant
module channel_scheduler
    import sched_pkg::*;
#(
    parameter int NCHAN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCHAN-1:0]     attention,
    input  logic [NCHAN-1:0]     overrun,
    input  logic [8*NCHAN-1:0]   chandata,
    output logic [2:0]           byteaddr,
    output logic [NCHAN-1:0]     unload,
    output logic [NCHAN-1:0]     clearoverrun,
    output logic [7:0]           txdata,
    output logic                 txvalid,
    input  logic                 txready
);

    localparam int IDXW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    state_t              state, state_nx;
    logic [IDXW-1:0]     ptr;
    logic [IDXW-1:0]     sel;
    logic                ovr;
    logic [HOLD_W-1:0]   hold_cnt;

    logic [IDXW-1:0]     grant_idx;
    logic                grant_any;
    logic [NCHAN-1:0]    sel_onehot;
    logic [IDXW-1:0]     ptr_after;
    logic                last_byte;

    rr_arbiter #(
        .NCHAN (NCHAN),
        .IDXW  (IDXW)
    ) u_arb (
        .req       (attention),
        .ptr       (ptr),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    assign ptr_after = (sel == IDXW'(NCHAN - 1)) ? '0 : sel + 1'b1;
    assign last_byte = (byteaddr == 3'(RECORD_BYTES - 1));

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (grant_any) state_nx = ST_HDR;
            ST_HDR:    if (txready) state_nx = ovr ? ST_HOLD : ST_FETCH;
            ST_FETCH:  state_nx = ST_SEND;
            ST_SEND:   if (txready) state_nx = last_byte ? ST_UNLOAD : ST_FETCH;
            ST_UNLOAD: state_nx = ST_HOLD;
            ST_HOLD:   if (hold_cnt == '0) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            sel          <= '0;
            ovr          <= 1'b0;
            hold_cnt     <= '0;
            byteaddr     <= '0;
            txdata       <= '0;
            txvalid      <= 1'b0;
            unload       <= '0;
            clearoverrun <= '0;
        end else begin
            state        <= state_nx;
            // Valid exactly in the offering states; a stall keeps the state,
            // so txvalid and txdata both hold until the transfer.
            txvalid      <= (state_nx == ST_HDR) || (state_nx == ST_SEND);
            unload       <= '0;
            clearoverrun <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        sel    <= grant_idx;
                        ovr    <= overrun[grant_idx];
                        txdata <= make_header(overrun[grant_idx], 4'(grant_idx));
                    end
                end
                ST_HDR: begin
                    if (txready) begin
                        if (ovr) begin
                            clearoverrun <= sel_onehot;
                            ptr          <= ptr_after;
                            hold_cnt     <= HOLD_W'(HOLD_CYCLES - 1);
                        end else begin
                            byteaddr <= '0;
                        end
                    end
                end
                ST_FETCH: begin
                    txdata <= chandata[{sel, 3'b000} +: 8];
                end
                ST_SEND: begin
                    if (txready) begin
                        if (last_byte) begin
                            unload <= sel_onehot;
                            ptr    <= ptr_after;
                        end else begin
                            byteaddr <= byteaddr + 3'd1;
                        end
                    end
                end
                ST_UNLOAD: begin
                    hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
                end
                ST_HOLD: begin
                    if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_scheduler.sv
// tb_channel_scheduler: self-checking bench for channel_scheduler.
// A channel model (word FIFOs + overrun latches, attention lagging one clock)
// feeds the DUT; a monitor records transferred bytes and pulses; a record-level
// reference model predicts the byte stream from the queued words and flags.
module tb_channel_scheduler;

    localparam int NCHAN = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCHAN-1:0]     attention;
    logic [NCHAN-1:0]     overrun;
    logic [8*NCHAN-1:0]   chandata;
    logic [2:0]           byteaddr;
    logic [NCHAN-1:0]     unload;
    logic [NCHAN-1:0]     clearoverrun;
    logic [7:0]           txdata;
    logic                 txvalid;
    logic                 txready;

    always #5 clk = ~clk;

    channel_scheduler #(.NCHAN(NCHAN)) dut (
        .clk          (clk),
        .rst          (rst),
        .attention    (attention),
        .overrun      (overrun),
        .chandata     (chandata),
        .byteaddr     (byteaddr),
        .unload       (unload),
        .clearoverrun (clearoverrun),
        .txdata       (txdata),
        .txvalid      (txvalid),
        .txready      (txready)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- channel model ----------------
    logic [63:0] fifo [NCHAN][$];
    bit          ovr_flag [NCHAN];
    logic [63:0] head_w [NCHAN];

    always_comb begin
        chandata = '0;
        for (int i = 0; i < NCHAN; i++)
            chandata[8*i +: 8] = 8'(head_w[i] >> (8 * byteaddr));
    end

    initial begin
        logic [NCHAN-1:0] nxt_att;
        attention = '0;
        overrun   = '0;
        for (int i = 0; i < NCHAN; i++) begin
            head_w[i]   = '0;
            ovr_flag[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCHAN; i++)
                nxt_att[i] = (fifo[i].size() != 0) || ovr_flag[i];
            for (int i = 0; i < NCHAN; i++) begin
                if (unload[i] === 1'b1 && fifo[i].size() != 0) void'(fifo[i].pop_front());
                if (clearoverrun[i] === 1'b1) ovr_flag[i] = 1'b0;
                head_w[i]  = (fifo[i].size() != 0) ? fifo[i][0] : 64'h0;
                overrun[i] = ovr_flag[i];
            end
            attention = nxt_att;
        end
    end

    // ---------------- txready driver ----------------
    bit rand_ready  = 1'b0;
    bit fixed_ready = 1'b1;

    initial begin
        txready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            txready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
        end
    end

    // ---------------- monitor ----------------
    logic [7:0] tx_q [$];
    int         tx_t [$];
    int         unl_t [$];
    int         clr_t [$];
    int         unl_cnt [NCHAN];
    int         clr_cnt [NCHAN];
    int         rec_done   = 0;
    int         valid_cyc  = 0;
    int         cyc        = 0;
    int         stall_bad  = 0;
    int         onehot_bad = 0;

    initial begin
        bit         prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (txvalid !== 1'b1 || txdata !== prev_data)) stall_bad++;
                if ($countones(unload) > 1 || $countones(clearoverrun) > 1) onehot_bad++;
                if (txvalid === 1'b1) valid_cyc++;
                if (txvalid === 1'b1 && txready === 1'b1) begin
                    tx_q.push_back(txdata);
                    tx_t.push_back(cyc);
                end
                for (int i = 0; i < NCHAN; i++) begin
                    if (unload[i] === 1'b1) begin
                        unl_cnt[i]++;
                        unl_t.push_back(cyc);
                        rec_done++;
                    end
                    if (clearoverrun[i] === 1'b1) begin
                        clr_cnt[i]++;
                        clr_t.push_back(cyc);
                        rec_done++;
                    end
                end
                prev_stall = (txvalid === 1'b1) && (txready !== 1'b1);
                prev_data  = txdata;
            end
        end
    end

    task automatic clear_mon();
        tx_q.delete();
        tx_t.delete();
        unl_t.delete();
        clr_t.delete();
        for (int i = 0; i < NCHAN; i++) begin
            unl_cnt[i] = 0;
            clr_cnt[i] = 0;
        end
        rec_done  = 0;
        valid_cyc = 0;
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q [$];
    int         exp_unl [NCHAN];
    int         exp_clr [NCHAN];
    int         exp_rec;
    int         model_ptr = 0;

    // Serve pending channels round-robin from model_ptr until none remain:
    // overrun first (header only), otherwise one word (header + 8 bytes LSB first).
    task automatic build_expected();
        logic [63:0] mq [NCHAN][$];
        bit          mo [NCHAN];
        int          p, found;
        bit          done;
        logic [63:0] w;
        exp_q.delete();
        exp_rec = 0;
        for (int i = 0; i < NCHAN; i++) begin
            mq[i]      = fifo[i];
            mo[i]      = ovr_flag[i];
            exp_unl[i] = 0;
            exp_clr[i] = 0;
        end
        p    = model_ptr;
        done = 1'b0;
        while (!done) begin
            found = -1;
            for (int k = 0; k < NCHAN; k++) begin
                int j;
                j = (p + k) % NCHAN;
                if (found < 0 && (mo[j] || mq[j].size() > 0)) found = j;
            end
            if (found < 0) begin
                done = 1'b1;
            end else begin
                if (mo[found]) begin
                    exp_q.push_back(8'h80 | 8'(found));
                    mo[found] = 1'b0;
                    exp_clr[found]++;
                end else begin
                    w = mq[found].pop_front();
                    exp_q.push_back(8'(found));
                    for (int b = 0; b < 8; b++) exp_q.push_back(w[8*b +: 8]);
                    exp_unl[found]++;
                end
                exp_rec++;
                p = (found + 1) % NCHAN;
            end
        end
        model_ptr = p;
    endtask

    task automatic wait_records(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge clk);
            #1;
            if (rec_done >= n) ok = 1'b1;
        end
        repeat (25) @(posedge clk);
        #1;
    endtask

    task automatic count_mismatch(output int nbad);
        int n;
        nbad = (tx_q.size() > exp_q.size()) ? tx_q.size() - exp_q.size()
                                            : exp_q.size() - tx_q.size();
        n = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (tx_q[i] !== exp_q[i]) nbad++;
    endtask

    task automatic load_word(input int ch, input logic [63:0] w);
        fifo[ch].push_back(w);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_ptr = 0;
        clear_mon();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (txvalid !== 1'b0) begin errors++; $display("FAIL reset_txvalid got %b want 0", txvalid); end
        checks++; if (txdata !== 8'h00) begin errors++; $display("FAIL reset_txdata got %h want 00", txdata); end
        checks++; if (byteaddr !== 3'd0) begin errors++; $display("FAIL reset_byteaddr got %0d want 0", byteaddr); end
        checks++; if (unload !== '0) begin errors++; $display("FAIL reset_unload got %b want 0", unload); end
        checks++; if (clearoverrun !== '0) begin errors++; $display("FAIL reset_clearoverrun got %b want 0", clearoverrun); end
        rst = 1'b0;
        model_ptr = 0;
        clear_mon();
        repeat (50) @(posedge clk);
        #1;
        checks++; if (valid_cyc !== 0) begin errors++; $display("FAIL idle_txvalid cycles got %0d want 0", valid_cyc); end
        checks++; if (rec_done !== 0) begin errors++; $display("FAIL idle_pulses got %0d want 0", rec_done); end
        checks++; if (byteaddr !== 3'd0) begin errors++; $display("FAIL idle_byteaddr got %0d want 0", byteaddr); end
    endtask

    task automatic test_single_record();
        logic [7:0] want [9];
        bit ok;
        int nbad;
        want = '{8'h02, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        rand_ready  = 1'b0;
        fixed_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        load_word(2, 64'h0123456789ABCDEF);
        load_word(2, 64'hFEDCBA9876543210);
        build_expected();
        wait_records(2, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout records got %0d want 2", rec_done); end
        checks++; if (tx_q.size() !== 18) begin errors++; $display("FAIL single_len got %0d want 18", tx_q.size()); end
        if (tx_q.size() >= 18) begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (tx_q[i] !== want[i]) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, tx_q[i], want[i]); end
            end
            checks++; if (tx_t[8] - tx_t[0] !== 16) begin errors++; $display("FAIL single_byte_spacing got %0d want 16", tx_t[8] - tx_t[0]); end
            checks++; if (tx_t[9] - tx_t[0] !== 21) begin errors++; $display("FAIL single_record_cycles got %0d want 21", tx_t[9] - tx_t[0]); end
            if (unl_t.size() > 0) begin
                checks++; if (unl_t[0] - tx_t[0] !== 17) begin errors++; $display("FAIL single_unload_time got %0d want 17", unl_t[0] - tx_t[0]); end
            end
        end
        count_mismatch(nbad);
        checks++; if (nbad !== 0) begin errors++; $display("FAIL single_stream mismatches got %0d want 0", nbad); end
        for (int i = 0; i < NCHAN; i++) begin
            checks++;
            if (unl_cnt[i] !== ((i == 2) ? 2 : 0)) begin errors++; $display("FAIL single_unload_ch%0d got %0d want %0d", i, unl_cnt[i], (i == 2) ? 2 : 0); end
        end
        checks++; if (clr_cnt[2] !== 0) begin errors++; $display("FAIL single_clear got %0d want 0", clr_cnt[2]); end
        checks++; if (byteaddr !== 3'd7) begin errors++; $display("FAIL single_byteaddr_hold got %0d want 7", byteaddr); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int nbad;
        do_reset();
        for (int i = 0; i < NCHAN; i++) load_word(i, {$urandom, $urandom});
        build_expected();
        wait_records(4, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout records got %0d want 4", rec_done); end
        if (tx_q.size() >= 36) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (tx_q[9*i] !== 8'(i)) begin errors++; $display("FAIL rr_header%0d got %h want %h", i, tx_q[9*i], 8'(i)); end
            end
        end
        count_mismatch(nbad);
        checks++; if (nbad !== 0) begin errors++; $display("FAIL rr_stream mismatches got %0d want 0", nbad); end
        // Pointer should have wrapped to 0: channel 0 beats channel 3.
        clear_mon();
        load_word(3, {$urandom, $urandom});
        load_word(0, {$urandom, $urandom});
        build_expected();
        wait_records(2, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_wrap_timeout records got %0d want 2", rec_done); end
        if (tx_q.size() >= 18) begin
            checks++; if (tx_q[0] !== 8'h00) begin errors++; $display("FAIL rr_wrap_first got %h want 00", tx_q[0]); end
            checks++; if (tx_q[9] !== 8'h03) begin errors++; $display("FAIL rr_wrap_second got %h want 03", tx_q[9]); end
        end
        count_mismatch(nbad);
        checks++; if (nbad !== 0) begin errors++; $display("FAIL rr_wrap_stream mismatches got %0d want 0", nbad); end
    endtask

    task automatic test_overrun();
        bit ok;
        int nbad;
        clear_mon();
        ovr_flag[1] = 1'b1;
        load_word(1, 64'hA5A5_0F0F_1234_5678);
        build_expected();
        wait_records(2, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovr_timeout records got %0d want 2", rec_done); end
        checks++; if (tx_q.size() !== 10) begin errors++; $display("FAIL ovr_len got %0d want 10", tx_q.size()); end
        if (tx_q.size() >= 2) begin
            checks++; if (tx_q[0] !== 8'h81) begin errors++; $display("FAIL ovr_header got %h want 81", tx_q[0]); end
            checks++; if (tx_q[1] !== 8'h01) begin errors++; $display("FAIL ovr_data_header got %h want 01", tx_q[1]); end
            checks++; if (tx_t[1] - tx_t[0] !== 4) begin errors++; $display("FAIL ovr_record_cycles got %0d want 4", tx_t[1] - tx_t[0]); end
            if (clr_t.size() > 0) begin
                checks++; if (clr_t[0] - tx_t[0] !== 1) begin errors++; $display("FAIL ovr_clear_time got %0d want 1", clr_t[0] - tx_t[0]); end
            end
            if (unl_t.size() > 0) begin
                checks++; if (unl_t[0] <= tx_t[1]) begin errors++; $display("FAIL ovr_unload_early at %0d header at %0d", unl_t[0], tx_t[1]); end
            end
        end
        checks++; if (clr_cnt[1] !== 1) begin errors++; $display("FAIL ovr_clear_count got %0d want 1", clr_cnt[1]); end
        checks++; if (unl_cnt[1] !== 1) begin errors++; $display("FAIL ovr_unload_count got %0d want 1", unl_cnt[1]); end
        count_mismatch(nbad);
        checks++; if (nbad !== 0) begin errors++; $display("FAIL ovr_stream mismatches got %0d want 0", nbad); end
    endtask

    task automatic test_random();
        bit ok;
        int nbad;
        for (int it = 0; it < 6; it++) begin
            rand_ready = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            clear_mon();
            for (int i = 0; i < NCHAN; i++) begin
                int nw;
                nw = $urandom_range(0, 2);
                for (int k = 0; k < nw; k++) load_word(i, {$urandom, $urandom});
                if ($urandom_range(0, 3) == 0) ovr_flag[i] = 1'b1;
            end
            if (fifo[it % NCHAN].size() == 0) load_word(it % NCHAN, {$urandom, $urandom});
            build_expected();
            wait_records(exp_rec, 4000, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout records got %0d want %0d", it, rec_done, exp_rec); end
            count_mismatch(nbad);
            checks++; if (nbad !== 0) begin errors++; $display("FAIL rand%0d_stream mismatches got %0d want 0 (len %0d vs %0d)", it, nbad, tx_q.size(), exp_q.size()); end
            for (int i = 0; i < NCHAN; i++) begin
                checks++; if (unl_cnt[i] !== exp_unl[i]) begin errors++; $display("FAIL rand%0d_unload_ch%0d got %0d want %0d", it, i, unl_cnt[i], exp_unl[i]); end
                checks++; if (clr_cnt[i] !== exp_clr[i]) begin errors++; $display("FAIL rand%0d_clear_ch%0d got %0d want %0d", it, i, clr_cnt[i], exp_clr[i]); end
            end
        end
        rand_ready = 1'b0;
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_stability violations got %0d want 0", stall_bad); end
    endtask

    task automatic test_reset_midrecord();
        bit ok, hit;
        int nbad;
        logic [63:0] w;
        w = 64'h1122_3344_5566_7788;
        fixed_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        load_word(1, w);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (tx_q.size() == 5 && txvalid === 1'b1) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL midrst_reach_byte4 got %0d bytes want 5", tx_q.size()); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (txvalid !== 1'b0) begin errors++; $display("FAIL midrst_txvalid got %b want 0", txvalid); end
        checks++; if (txdata !== 8'h00) begin errors++; $display("FAIL midrst_txdata got %h want 00", txdata); end
        checks++; if (byteaddr !== 3'd0) begin errors++; $display("FAIL midrst_byteaddr got %0d want 0", byteaddr); end
        checks++; if (unload !== '0 || clearoverrun !== '0) begin errors++; $display("FAIL midrst_pulses got %b/%b want 0/0", unload, clearoverrun); end
        checks++; if (unl_cnt[1] !== 0) begin errors++; $display("FAIL midrst_no_unload got %0d want 0", unl_cnt[1]); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_ptr = 0;
        clear_mon();
        build_expected();
        wait_records(1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout records got %0d want 1", rec_done); end
        if (tx_q.size() >= 2) begin
            checks++; if (tx_q[1] !== w[7:0]) begin errors++; $display("FAIL midrst_restart_byte0 got %h want %h", tx_q[1], w[7:0]); end
        end
        count_mismatch(nbad);
        checks++; if (nbad !== 0) begin errors++; $display("FAIL midrst_stream mismatches got %0d want 0", nbad); end
        checks++; if (unl_cnt[1] !== 1) begin errors++; $display("FAIL midrst_unload got %0d want 1", unl_cnt[1]); end
    endtask

    initial begin
        rst = 1'b1;
        clear_mon();
        test_reset();
        test_single_record();
        test_round_robin();
        test_overrun();
        test_random();
        test_reset_midrecord();
        checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL pulse_onehot violations got %0d want 0", onehot_bad); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
